// File: rtl/piso_pkg.sv
// Shared state encoding for the parallel-in serial-out transmitter.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } piso_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with load/ready handshake and zero-gap back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit cycle after the WIDTH data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  piso_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_start;
  logic             r_done;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  logic w_last_data;
  logic w_final;
  logic w_accept;
  logic w_sout;

  assign w_last_data = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
  assign w_final = (r_state == S_PARITY);
`else
  assign w_final = w_last_data;
`endif

  // ready opens during the final frame bit so the next word streams with no gap
  assign ready    = (r_state == S_IDLE) || w_final;
  assign w_accept = load && ready;

  always_comb begin
    w_sout = 1'b0;
    case (r_state)
      S_SHIFT:  w_sout = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
`ifdef PISO_PARITY_EN
      S_PARITY: w_sout = r_par;
`endif
      default:  w_sout = 1'b0;
    endcase
  end

  assign sout        = w_sout;
  assign sout_valid  = (r_state != S_IDLE);
  assign frame_start = r_frame_start;
  assign done        = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par         <= 1'b0;
`endif
    end else begin
      r_frame_start <= w_accept;
      r_done        <= w_final;
      if (w_accept) begin
        r_state <= S_SHIFT;
        r_shreg <= pdata;
        r_cnt   <= '0;
`ifdef PISO_PARITY_EN
        r_par   <= ^pdata;
`endif
      end else begin
        case (r_state)
          S_SHIFT: begin
            r_shreg <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
            if (w_last_data) begin
              r_cnt <= '0;
`ifdef PISO_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_IDLE;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share stimulus; a frame-level model
// queues the expected bits of every accepted word and a negedge monitor compares them.
module tb_piso_serializer;

  localparam int W = 8;

  typedef struct {
    bit b;
    bit first;
    bit last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] pdata = '0;

  logic ready  [2];
  logic sout   [2];
  logic svalid [2];
  logic fstart [2];
  logic done   [2];

  exp_t q [2][$];
  bit   exp_done [2];
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load(load), .pdata(pdata),
    .ready(ready[0]), .sout(sout[0]), .sout_valid(svalid[0]),
    .frame_start(fstart[0]), .done(done[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load(load), .pdata(pdata),
    .ready(ready[1]), .sout(sout[1]), .sout_valid(svalid[1]),
    .frame_start(fstart[1]), .done(done[1])
  );

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t actual=%b expected=%b", nm, k, $time, act, exp);
    end
  endtask

  // Reference: a frame is the word's bits in transmit order, plus its parity bit when enabled.
  task automatic push_frame(input int k, input logic [W-1:0] d);
    int   n;
    exp_t e;
`ifdef PISO_PARITY_EN
    n = W + 1;
`else
    n = W;
`endif
    for (int i = 0; i < n; i++) begin
      if (i < W) e.b = (k == 0) ? d[W-1-i] : d[i];
      else       e.b = ^d;
      e.first = (i == 0);
      e.last  = (i == n - 1);
      q[k].push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (reset) chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        q[k].delete();
        exp_done[k] = 1'b0;
      end else begin
        bit rdy;
        rdy         = (q[k].size() <= 1);
        exp_done[k] = (q[k].size() != 0) && q[k][0].last;
        if (q[k].size() != 0) void'(q[k].pop_front());
        if (load && rdy) push_frame(k, pdata);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit v;
        v = (q[k].size() != 0);
        chk("sout_valid", k, svalid[k], v);
        chk("ready", k, ready[k], q[k].size() <= 1);
        chk("done", k, done[k], exp_done[k]);
        if (v) begin
          chk("sout", k, sout[k], q[k][0].b);
          chk("frame_start", k, fstart[k], q[k][0].first);
        end else begin
          chk("sout_idle", k, sout[k], 1'b0);
          chk("frame_start_idle", k, fstart[k], 1'b0);
        end
      end
    end
  end

  task automatic drive(input bit l, input logic [W-1:0] d, input bit r, input int n);
    load  = l;
    pdata = d;
    reset = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(0, 8'h00, 0, 3);
    // single frame from idle
    drive(1, 8'hAA, 0, 1);
    drive(0, 8'h00, 0, 12);
    // back-to-back: second word offered during the final data bit
    drive(1, 8'hAA, 0, 1);
    drive(0, 8'h00, 0, 7);
    drive(1, 8'hCC, 0, 1);
    drive(0, 8'h00, 0, 14);
    // load while busy must be ignored
    drive(1, 8'hF0, 0, 1);
    drive(0, 8'h00, 0, 2);
    drive(1, 8'h0F, 0, 1);
    drive(0, 8'h00, 0, 12);
    // mid-frame reset discards the word with no done pulse
    drive(1, 8'hAA, 0, 1);
    drive(0, 8'h00, 0, 3);
    drive(0, 8'h00, 1, 1);
    drive(0, 8'h00, 0, 6);
    // single-bit word and parity-sensitive words
    drive(1, 8'h01, 0, 1);
    drive(0, 8'h00, 0, 12);
    drive(1, 8'hA8, 0, 1);
    drive(0, 8'h00, 0, 12);
    drive(1, 8'hAA, 0, 1);
    drive(0, 8'h00, 0, 12);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), W'($urandom), ($urandom_range(0, 63) == 0), 1);
    end
    drive(0, 8'h00, 0, 12);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
